io_input_conditioner: RTL and testbench
=======================================

// Module: io_input_conditioner
// PURPOSE
//  Conditions the raw DE2 board switches and push-keys before they reach the
//  core's io_sw_i / io_key_i inputs, which the LSU reads as memory-mapped input.
//  Per bit: 2-flop synchroniser, counter debouncer, rise/fall event pulses.
//  Keys are active-low on the pins and are presented active-high (1 = pressed).
//  Outputs are zero-extended to 32 bits so the LSU reads clean, stable words.
// PARAMETERS
//  SW_W       18       number of slide switches conditioned
//  KEY_W      4        number of push keys conditioned
//  DB_CYCLES  500000   cycles a synced input must differ from the stable value before it is accepted (10 ms @ 50 MHz); legal range 2..2^20
//  CNT_W      20       debounce counter width; must satisfy 2^CNT_W >= DB_CYCLES
// PORTS
//  clk_i          in   1      system clock, same clock as the core
//  rst_ni         in   1      reset, synchronous, active-low
//  sw_raw_i       in   SW_W   raw switch pins, asynchronous, 1 = up
//  key_raw_ni     in   KEY_W  raw key pins, asynchronous, 0 = pressed
//  io_sw_o        out  32     {zeros, debounced switches}, feeds core io_sw_i
//  io_key_o       out  32     {zeros, debounced keys, 1 = pressed}, feeds core io_key_i
//  key_press_o    out  KEY_W  one-cycle pulse on each debounced key press (0->1)
//  key_release_o  out  KEY_W  one-cycle pulse on each debounced key release (1->0)
// BEHAVIOUR
//  - Reset (rst_ni==0 at a rising edge): sync flops load the inactive value
//    (switch 0; key pin 1, i.e. not pressed); stable state 0; counters 0;
//    io_sw_o, io_key_o, key_press_o and key_release_o all 0. Reset asserted
//    mid-count discards the count; no event pulse is produced by reset.
//  - Sync: s1 <= pin; s2 <= s1. Keys are inverted before s1.
//  - Debounce, per bit, state {stable, cnt}:
//      s2 == stable                      -> cnt <= 0
//      s2 != stable, cnt <  DB_CYCLES-1  -> cnt <= cnt+1
//      s2 != stable, cnt == DB_CYCLES-1  -> stable <= s2, cnt <= 0
//    Any glitch shorter than DB_CYCLES cycles (after sync) restarts the count
//    and never changes stable. The counter never wraps.
//  - Latency: a pin that changes before clock edge k and then holds is
//    reflected in io_*_o after edge k+1+DB_CYCLES (2 sync edges, DB_CYCLES
//    count edges, the last of which also updates stable). io_*_o is driven
//    directly from the stable flops (no extra register).
//  - Events: key_press_o[i] = 1 for exactly the one cycle following the edge
//    at which stable[i] goes 0->1; key_release_o[i] likewise for 1->0.
//    Registered; mutually exclusive per bit; independent across bits, so
//    simultaneous presses on several keys pulse in the same cycle.
//  - Bits above SW_W / KEY_W in io_sw_o / io_key_o are constant 0.
//  - Switches carry no event outputs; their level only.
// STRUCTURE
//  - Shared package io_pkg: SW_W, KEY_W defaults, DB_CYCLES default, CNT_W,
//    and the 32-bit IO word width used across the LSU boundary.
//  - Sub-module debounce_bit (sync + counter + stable flop + edge flags),
//    instantiated SW_W + KEY_W times via generate; the top inverts keys,
//    zero-extends outputs and gathers the pulses.
// TESTING  (bench uses DB_CYCLES=4, CNT_W=3)
//  1 Reset: hold rst_ni=0 for 3 cycles with sw_raw_i=18'h3FFFF, key_raw_ni=0
//    -> all outputs 0 during reset; first update occurs 6 edges after release.
//  2 Clean press: key_raw_ni 4'hF->4'hE before edge k, held -> io_key_o=32'h1
//    after edge k+5; key_press_o=4'h1 for exactly one cycle; no release pulse.
//  3 Bounce: sw_raw_i[3] toggles 1,0,1 with 1-cycle phases, then holds 1
//    -> io_sw_o stays 0 until DB_CYCLES cycles after the last toggle, then 32'h8.
//  4 Glitch reject: key_raw_ni[2] low for 3 cycles (< DB_CYCLES) -> io_key_o
//    and both pulse outputs stay 0 throughout.
//  5 Simultaneous: all four keys pressed in the same cycle -> key_press_o=4'hF
//    for one cycle; released together -> key_release_o=4'hF for one cycle.
//  6 Reset mid-count: switch 0 changes, rst_ni pulsed low 2 cycles into the
//    count -> io_sw_o=0; after release the full 6-edge latency is required.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants for the board input conditioner and the LSU IO boundary.
package io_pkg;

  // Word width the LSU reads for memory-mapped inputs.
  localparam int unsigned IO_W          = 32;

  // Default conditioner geometry for the DE2 board.
  localparam int unsigned SW_W_DEF      = 18;
  localparam int unsigned KEY_W_DEF     = 4;

  // 10 ms at 50 MHz; the counter width must hold DB_CYCLES-1.
  localparam int unsigned DB_CYCLES_DEF = 500000;
  localparam int unsigned CNT_W_DEF     = 20;

  // True when a counter of cnt_w bits can reach db_cycles-1 without wrapping.
  function automatic bit cnt_fits(input int unsigned db_cycles, input int unsigned cnt_w);
    return (64'(db_cycles) <= (64'(1) << cnt_w));
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One conditioned input bit: 2-flop synchroniser, counter debouncer and
// registered rise/fall flags. The input is already in active-high form.
module debounce_bit
  import io_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall
);

  // Last count value; reaching it while still differing accepts the new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;

  logic             w_differ;
  logic             w_accept;

  assign w_differ = r_s2 ^ r_stable;
  assign w_accept = w_differ && (r_cnt == CNT_LAST);

  // Synchronise, count how long the synced level has differed, and accept it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_s1   <= i_raw;
      r_s2   <= r_s1;
      // Edge flags are set on the same edge that flips the stable level.
      r_rise <= w_accept & r_s2;
      r_fall <= w_accept & ~r_s2;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stable = r_stable;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;

endmodule

// File: rtl/io_input_conditioner.sv
// Conditions raw DE2 switches and active-low push keys into clean 32-bit
// words for the core's memory-mapped inputs, plus key press/release pulses.
module io_input_conditioner
  import io_pkg::*;
#(
  parameter int unsigned SW_W      = SW_W_DEF,
  parameter int unsigned KEY_W     = KEY_W_DEF,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [SW_W-1:0]   sw_raw_i,
  input  logic [KEY_W-1:0]  key_raw_ni,
  output logic [IO_W-1:0]   io_sw_o,
  output logic [IO_W-1:0]   io_key_o,
  output logic [KEY_W-1:0]  key_press_o,
  output logic [KEY_W-1:0]  key_release_o
);

  logic [SW_W-1:0]  w_sw_stable;
  logic [SW_W-1:0]  w_sw_rise_unused;
  logic [SW_W-1:0]  w_sw_fall_unused;
  logic [KEY_W-1:0] w_key_stable;

  // Switches: level only, the edge flags are left unconnected downstream.
  for (genvar g = 0; g < SW_W; g++) begin : g_sw
    debounce_bit #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_db (
      .i_clk    (clk_i),
      .i_rst_n  (rst_ni),
      .i_raw    (sw_raw_i[g]),
      .o_stable (w_sw_stable[g]),
      .o_rise   (w_sw_rise_unused[g]),
      .o_fall   (w_sw_fall_unused[g])
    );
  end

  // Keys: inverted ahead of the synchroniser so 1 means pressed everywhere.
  for (genvar g = 0; g < KEY_W; g++) begin : g_key
    debounce_bit #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_db (
      .i_clk    (clk_i),
      .i_rst_n  (rst_ni),
      .i_raw    (~key_raw_ni[g]),
      .o_stable (w_key_stable[g]),
      .o_rise   (key_press_o[g]),
      .o_fall   (key_release_o[g])
    );
  end

  // Zero-extend the stable levels straight from their flops.
  assign io_sw_o  = IO_W'(w_sw_stable);
  assign io_key_o = IO_W'(w_key_stable);

endmodule

// File: tb/tb_io_input_conditioner.sv
// Self-checking bench for io_input_conditioner with DB_CYCLES=4, CNT_W=3.
// The model records the value each edge loads into the first sync stage and
// flips a stable level when the last DB synced samples all disagree with it.
module tb_io_input_conditioner;

  localparam int DB  = 4;
  localparam int SWW = 18;
  localparam int KW  = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [SWW-1:0]  sw_raw_i;
  logic [KW-1:0]   key_raw_ni;
  logic [31:0]     io_sw_o;
  logic [31:0]     io_key_o;
  logic [KW-1:0]   key_press_o;
  logic [KW-1:0]   key_release_o;

  int n_cmp  = 0;
  int n_fail = 0;

  io_input_conditioner #(
    .SW_W      (SWW),
    .KEY_W     (KW),
    .DB_CYCLES (DB),
    .CNT_W     (3)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .sw_raw_i      (sw_raw_i),
    .key_raw_ni    (key_raw_ni),
    .io_sw_o       (io_sw_o),
    .io_key_o      (io_key_o),
    .key_press_o   (key_press_o),
    .key_release_o (key_release_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- behavioural model ----------------
  logic [31:0] h_sw  [0:1023];
  logic [31:0] h_key [0:1023];
  int          ec = 0;
  logic [31:0] m_sw, m_key;
  logic [3:0]  m_press, m_rel;
  bit          chk_en = 1'b0;

  function automatic logic [31:0] hist(input bit is_key, input int j);
    if (j < 0) return 32'h0;
    return is_key ? h_key[j] : h_sw[j];
  endfunction

  // New stable word after edge e: bit flips if synced samples seen by edges
  // e-DB+1..e (loaded at edges e-1-DB..e-2) all differ from the current level.
  function automatic logic [31:0] nxt(input logic [31:0] st, input int e, input bit is_key, input int w);
    logic [31:0] r;
    r = st;
    for (int b = 0; b < w; b++) begin
      bit all_diff;
      all_diff = 1'b1;
      for (int j = e - 1 - DB; j <= e - 2; j++) begin
        logic [31:0] v;
        v = hist(is_key, j);
        if (v[b] == st[b]) all_diff = 1'b0;
      end
      if (all_diff) r[b] = ~st[b];
    end
    return r;
  endfunction

  always @(posedge clk_i) begin
    logic [31:0] ns, nk;
    if (!rst_ni) begin
      h_sw[ec]  <= 32'h0;
      h_key[ec] <= 32'h0;
      m_sw      <= 32'h0;
      m_key     <= 32'h0;
      m_press   <= 4'h0;
      m_rel     <= 4'h0;
    end else begin
      ns = nxt(m_sw, ec, 1'b0, SWW);
      nk = nxt(m_key, ec, 1'b1, KW);
      h_sw[ec]  <= 32'(sw_raw_i);
      h_key[ec] <= 32'(~key_raw_ni);
      m_sw      <= ns;
      m_key     <= nk;
      m_press   <= nk[3:0] & ~m_key[3:0];
      m_rel     <= ~nk[3:0] & m_key[3:0];
    end
    ec     <= ec + 1;
    chk_en <= 1'b1;
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk_i) begin
    if (chk_en) begin
      n_cmp++;
      if (io_sw_o !== m_sw || io_key_o !== m_key ||
          key_press_o !== m_press || key_release_o !== m_rel) begin
        n_fail++;
        $display("FAIL model t=%0t sw got %h exp %h key got %h exp %h press got %h exp %h rel got %h exp %h",
                 $time, io_sw_o, m_sw, io_key_o, m_key, key_press_o, m_press, key_release_o, m_rel);
      end
    end
  end

  // Records any key activity while a short glitch is being applied.
  bit in_glitch = 1'b0;
  bit glitch_seen = 1'b0;
  always @(negedge clk_i) begin
    if (in_glitch && (io_key_o != 32'h0 || key_press_o != 4'h0 || key_release_o != 4'h0))
      glitch_seen <= 1'b1;
  end

  // ---------------- directed literal checks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    // 1 Reset with all inputs active
    rst_ni     = 1'b0;
    sw_raw_i   = 18'h3FFFF;
    key_raw_ni = 4'h0;
    step(3);
    check("rst_sw", io_sw_o, 32'h0);
    check("rst_key", io_key_o, 32'h0);
    check("rst_press", 32'(key_press_o), 32'h0);
    rst_ni = 1'b1;
    step(5);
    check("rel_sw_e5", io_sw_o, 32'h0);
    step(1);
    check("rel_sw_e6", io_sw_o, 32'h0003FFFF);
    check("rel_key_e6", io_key_o, 32'h0000000F);
    check("rel_press_e6", 32'(key_press_o), 32'hF);
    sw_raw_i   = 18'h0;
    key_raw_ni = 4'hF;
    step(8);
    check("idle_sw", io_sw_o, 32'h0);
    check("idle_key", io_key_o, 32'h0);

    // 2 Clean press of key 0
    key_raw_ni = 4'hE;
    step(5);
    check("press_k4", io_key_o, 32'h0);
    step(1);
    check("press_k5_key", io_key_o, 32'h1);
    check("press_k5_pulse", 32'(key_press_o), 32'h1);
    check("press_k5_rel", 32'(key_release_o), 32'h0);
    step(1);
    check("press_k6_pulse", 32'(key_press_o), 32'h0);
    key_raw_ni = 4'hF;
    step(8);

    // 3 Bounce on switch 3
    sw_raw_i[3] = 1'b1; step(1);
    sw_raw_i[3] = 1'b0; step(1);
    sw_raw_i[3] = 1'b1;
    step(5);
    check("bounce_k4", io_sw_o, 32'h0);
    step(1);
    check("bounce_k5", io_sw_o, 32'h8);
    sw_raw_i = 18'h0;
    step(8);

    // 4 Glitch on key 2 shorter than DB
    in_glitch  = 1'b1;
    key_raw_ni = 4'hB;
    step(3);
    key_raw_ni = 4'hF;
    step(10);
    in_glitch  = 1'b0;
    check("glitch_seen", 32'(glitch_seen), 32'h0);

    // 5 All keys together
    key_raw_ni = 4'h0;
    step(5);
    check("all_k4", 32'(key_press_o), 32'h0);
    step(1);
    check("all_press", 32'(key_press_o), 32'hF);
    check("all_key", io_key_o, 32'hF);
    step(1);
    check("all_press_end", 32'(key_press_o), 32'h0);
    key_raw_ni = 4'hF;
    step(5);
    check("all_rel_k4", 32'(key_release_o), 32'h0);
    step(1);
    check("all_release", 32'(key_release_o), 32'hF);
    check("all_key_off", io_key_o, 32'h0);
    step(1);
    check("all_release_end", 32'(key_release_o), 32'h0);

    // 6 Reset part-way into a count on switch 0
    sw_raw_i[0] = 1'b1;
    step(4);
    rst_ni = 1'b0;
    step(2);
    check("midrst_sw", io_sw_o, 32'h0);
    rst_ni = 1'b1;
    step(5);
    check("midrst_e5", io_sw_o, 32'h0);
    step(1);
    check("midrst_e6", io_sw_o, 32'h1);
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
